// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one saturating ALU between two requesters, one-entry response buffer, architectural {N,Z,V}; perf counters under ALU_ARBITER_PERF_EN
module alu_arbiter #(
  parameter int DW   = 16,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [DW-1:0]   req0_src1,
  input  logic [DW-1:0]   req0_src2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [DW-1:0]   req1_src1,
  input  logic [DW-1:0]   req1_src2,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_data,
  output logic [2:0]      rsp_flags,
  output logic [2:0]      flags_q
`ifdef ALU_ARBITER_PERF_EN
  ,
  output logic [CNTW-1:0] perf_grant0,
  output logic [CNTW-1:0] perf_grant1,
  output logic [CNTW-1:0] perf_stall
`endif
);
  localparam int SHW = $clog2(DW);
  logic            ptr_q, ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [2:0]      rsp_flags_q, rsp_flags_d;
  logic [2:0]      flags_d;
  logic            out_free, grant0, grant1, acc0, acc1, acc;
  logic [OPW-1:0]  op;
  logic [DW-1:0]   a, b, res;
  logic            ovf;
  logic [2:0]      raw;
  logic [DW:0]     sum_x, dif_x;
  logic            add_ov, sub_ov;
  logic [DW-1:0]   add_s, sub_s, pb, max_p, min_n;
  logic [DW/8-1:0] pov;
  logic [2*DW-1:0] rot;
  logic [SHW-1:0]  sh;
  logic            full_upd, z_upd;

  assign out_free   = ~rsp_valid_q | rsp_ready;
  assign grant0     = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1     = req1_valid & (~req0_valid | ptr_q);
  assign req0_ready = grant0 & out_free & ~flush;
  assign req1_ready = grant1 & out_free & ~flush;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign acc        = acc0 | acc1;

  assign op = grant1 ? req1_op : req0_op;
  assign a  = grant1 ? req1_src1 : req0_src1;
  assign b  = grant1 ? req1_src2 : req0_src2;
  assign sh = b[SHW-1:0];

  assign max_p  = {1'b0, {(DW-1){1'b1}}};
  assign min_n  = {1'b1, {(DW-1){1'b0}}};
  assign sum_x  = {a[DW-1], a} + {b[DW-1], b};
  assign dif_x  = {a[DW-1], a} - {b[DW-1], b};
  assign add_ov = sum_x[DW] ^ sum_x[DW-1];
  assign sub_ov = dif_x[DW] ^ dif_x[DW-1];
  assign add_s  = add_ov ? (sum_x[DW] ? min_n : max_p) : sum_x[DW-1:0];
  assign sub_s  = sub_ov ? (dif_x[DW] ? min_n : max_p) : dif_x[DW-1:0];
  assign rot    = {a, a} >> sh;

  for (genvar g = 0; g < DW / 8; g++) begin : g_byte
    logic [8:0] s;
    assign s = {a[8*g+7], a[8*g+:8]} + {b[8*g+7], b[8*g+:8]};
    assign pov[g] = s[8] ^ s[7];
    assign pb[8*g+:8] = pov[g] ? (s[8] ? 8'h80 : 8'h7F) : s[7:0];
  end

  // shared ALU; 0x0 and every unlisted 1xxx opcode behave as saturating ADD
  always_comb begin
    res = add_s;
    ovf = add_ov;
    case (op)
      4'h1: begin res = sub_s; ovf = sub_ov; end
      4'h2: begin res = a ^ b; ovf = 1'b0; end
      4'h3: begin res = {{(DW-1){1'b0}}, ^a}; ovf = 1'b0; end
      4'h4: begin res = a << sh; ovf = 1'b0; end
      4'h5: begin res = $signed(a) >>> sh; ovf = 1'b0; end
      4'h6: begin res = rot[DW-1:0]; ovf = 1'b0; end
      4'h7: begin res = pb; ovf = |pov; end
      4'hA: begin res = {a[DW-1:8], b[7:0]}; ovf = 1'b0; end
      4'hB: begin res = {b[DW-1:8], a[7:0]}; ovf = 1'b0; end
      default: ;
    endcase
  end

  assign raw      = {res[DW-1], ~|res, ovf};
  assign full_upd = (op == 4'h0) | (op == 4'h1);
  assign z_upd    = (op == 4'h2) | (op == 4'h4) | (op == 4'h5) | (op == 4'h6);

  // only requester 0 is architectural; shifts/XOR refresh Z alone
  always_comb begin
    flags_d = !acc0 ? flags_q : full_upd ? raw : z_upd ? {flags_q[2], raw[1], flags_q[0]} : flags_q;
  end

  // response buffer load/drain and round-robin pointer advance
  always_comb begin
    rsp_valid_d = flush ? 1'b0 : acc ? 1'b1 : rsp_ready ? 1'b0 : rsp_valid_q;
    rsp_id_d    = acc ? acc1 : rsp_id_q;
    rsp_data_d  = acc ? res : rsp_data_q;
    rsp_flags_d = acc ? raw : rsp_flags_q;
    ptr_d       = acc ? acc0 : ptr_q;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      flags_q     <= '0;
      ptr_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;

`ifdef ALU_ARBITER_PERF_EN
  logic [CNTW-1:0] perf_grant0_q, perf_grant0_d;
  logic [CNTW-1:0] perf_grant1_q, perf_grant1_d;
  logic [CNTW-1:0] perf_stall_q, perf_stall_d;
  logic            stall;

  assign stall = (req0_valid | req1_valid) & ~acc;

  // counters stick at all-ones instead of wrapping
  always_comb begin
    perf_grant0_d = perf_grant0_q + CNTW'(acc0 & ~&perf_grant0_q);
    perf_grant1_d = perf_grant1_q + CNTW'(acc1 & ~&perf_grant1_q);
    perf_stall_d  = perf_stall_q + CNTW'(stall & ~&perf_stall_q);
  end

  // perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_grant0_q <= perf_grant0_d;
      perf_grant1_q <= perf_grant1_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; expected responses queued at accept, checked by a monitor on consume
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic        flush = 1'b0;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags, flags_q;
`ifdef ALU_ARBITER_PERF_EN
  logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags_q(flags_q)
`ifdef ALU_ARBITER_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  typedef struct packed {
    logic        id;
    logic [15:0] d;
    logic [2:0]  f;
    logic [2:0]  a;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  f0_op [3] = '{4'h0, 4'h4, 4'h2};
  logic [15:0] f0_a  [3] = '{16'h4000, 16'h0001, 16'h00FF};
  logic [15:0] f0_b  [3] = '{16'h4000, 16'h0004, 16'h00FF};
  logic [3:0]  f1_op [3] = '{4'h0, 4'h7, 4'h5};
  logic [15:0] f1_a  [3] = '{16'h8000, 16'h7F01, 16'h8000};
  logic [15:0] f1_b  [3] = '{16'hFFFF, 16'h0101, 16'h0004};
  exp_t fair_exp [6] = '{
    exp_t'({1'b0, 16'h7FFF, 3'b001, 3'b001}),
    exp_t'({1'b1, 16'h8000, 3'b101, 3'b001}),
    exp_t'({1'b0, 16'h0010, 3'b000, 3'b001}),
    exp_t'({1'b1, 16'h7F02, 3'b001, 3'b001}),
    exp_t'({1'b0, 16'h0000, 3'b010, 3'b011}),
    exp_t'({1'b1, 16'hF800, 3'b100, 3'b011})
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic id, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ed, input logic [2:0] ef, input logic [2:0] ea, input logic push);
    logic got = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_src1 = x; req1_src2 = y;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_src1 = x; req0_src2 = y;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    chk("accept_wait", {31'b0, got}, 32'd1);
    if (push) q.push_back(exp_t'({id, ed, ef, ea}));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h expected none", rsp_id, rsp_data);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, mon_e.id});
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, mon_e.d});
        chk("rsp_flags", {29'b0, rsp_flags}, {29'b0, mon_e.f});
        chk("flags_q", {29'b0, flags_q}, {29'b0, mon_e.a});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0 = 0;
    int i1 = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_id", {31'b0, rsp_id}, 32'd0);
    chk("rst_data", {16'b0, rsp_data}, 32'd0);
    chk("rst_rflags", {29'b0, rsp_flags}, 32'd0);
    chk("rst_flags_q", {29'b0, flags_q}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001, 3'b001, 1'b1);
    do_op(1'b0, 4'h2, 16'h1234, 16'h1234, 16'h0000, 3'b010, 3'b011, 1'b1);
    do_op(1'b1, 4'hA, 16'hAB12, 16'h34CD, 16'hABCD, 3'b100, 3'b011, 1'b1);

    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      #1;
      req0_valid = (i0 < 3);
      if (i0 < 3) begin req0_op = f0_op[i0]; req0_src1 = f0_a[i0]; req0_src2 = f0_b[i0]; end
      req1_valid = (i1 < 3);
      if (i1 < 3) begin req1_op = f1_op[i1]; req1_src1 = f1_a[i1]; req1_src2 = f1_b[i1]; end
      @(negedge clk);
      chk("fair_rdy0", {31'b0, req0_ready}, {31'b0, c % 2 == 0});
      chk("fair_rdy1", {31'b0, req1_ready}, {31'b0, c % 2 == 1});
      q.push_back(fair_exp[c]);
      if (req0_ready) i0++;
      if (req1_ready) i1++;
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_op(1'b0, 4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b100, 3'b001, 1'b1);
    req1_valid = 1'b1; req1_op = 4'h1; req1_src1 = 16'h0010; req1_src2 = 16'h0001;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy0", {31'b0, req0_ready}, 32'd0);
      chk("bp_rdy1", {31'b0, req1_ready}, 32'd0);
      chk("bp_data", {16'b0, rsp_data}, 32'h8000);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", {31'b0, req1_ready}, 32'd1);
    q.push_back(exp_t'({1'b1, 16'h000F, 3'b000, 3'b001}));
    @(posedge clk); #1 req1_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_op(1'b0, 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 3'b100, 3'b100, 1'b0);
    @(negedge clk);
    chk("sub_valid", {31'b0, rsp_valid}, 32'd1);
    chk("sub_data", {16'b0, rsp_data}, 32'hFFFF);
    chk("sub_rflags", {29'b0, rsp_flags}, 32'd4);
    chk("sub_flags_q", {29'b0, flags_q}, 32'd4);
    @(posedge clk); #1;
    flush = 1'b1;
    req1_valid = 1'b1; req1_op = 4'h3; req1_src1 = 16'h0007; req1_src2 = 16'h0000;
    @(negedge clk);
    chk("flush_rdy1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'b0, rsp_valid}, 32'd0);
    chk("flush_flags_q", {29'b0, flags_q}, 32'd4);

    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req1_valid = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h9; req0_src1 = 16'h0001; req0_src2 = 16'h0002;
    @(negedge clk);
    chk("ptr_rdy1", {31'b0, req1_ready}, 32'd1);
    chk("ptr_rdy0", {31'b0, req0_ready}, 32'd0);
    q.push_back(exp_t'({1'b1, 16'h0001, 3'b000, 3'b100}));
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("ptr_next0", {31'b0, req0_ready}, 32'd1);
    q.push_back(exp_t'({1'b0, 16'h0003, 3'b000, 3'b100}));
    @(posedge clk); #1 req0_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_op(1'b0, 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 3'b100, 3'b100, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_flags_q", {29'b0, flags_q}, 32'd0);
    chk("arst_data", {16'b0, rsp_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy0", {31'b0, req0_ready}, 32'd0);
    chk("post_rst_rdy1", {31'b0, req1_ready}, 32'd0);

    repeat (3) do_op(1'b0, 4'h0, 16'h0001, 16'h0001, 16'h0002, 3'b000, 3'b000, 1'b1);
    repeat (2) do_op(1'b1, 4'h0, 16'h0001, 16'h0001, 16'h0002, 3'b000, 3'b000, 1'b1);
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_op(1'b0, 4'h0, 16'h0001, 16'h0001, 16'h0002, 3'b000, 3'b000, 1'b1);
    req1_valid = 1'b1; req1_op = 4'h0; req1_src1 = 16'h0001; req1_src2 = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
`ifdef ALU_ARBITER_PERF_EN
    chk("perf_grant0", {16'b0, perf_grant0}, 32'd4);
    chk("perf_grant1", {16'b0, perf_grant1}, 32'd2);
    chk("perf_stall", {16'b0, perf_stall}, 32'd3);
`endif

    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
